// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/ERET sequencer: picks the winning exception at commit, updates CP0 and redirects fetch.
// Latency: redirect_valid and the CP0 strobes appear 1 cycle after the triggering commit.
// Backpressure: busy is high outside IDLE and the upstream commit is ignored until IDLE returns.
// Optional feature macro: CP0_EXC_TLB_REFILL_EN (TLB refill vector offset 0x000 plus a Context/EntryHi write strobe).
module cp0_exc_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_dslot,
    input  logic [31:0] commit_badva,
    input  logic [10:0] exc_req,
    input  logic        tlb_refill,
    input  logic        eret_req,
    input  logic [31:0] status,
    input  logic [31:0] cause,
    input  logic [31:0] ebase,
    input  logic [31:0] eret_pc,
    output logic        is_exception,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_epc,
    output logic        badva_we,
    output logic [31:0] exc_badva,
    output logic        ctx_we,
    output logic        eret,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXC   = 2'd1,
        S_ERET  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_exception_q, is_exception_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic [31:0] exc_epc_q, exc_epc_d;
    logic        badva_we_q, badva_we_d;
    logic [31:0] exc_badva_q, exc_badva_d;
    logic        ctx_we_q, ctx_we_d;
    logic        eret_q, eret_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        flush_q, flush_d;
    logic        busy_q, busy_d;

    // Decoded view of the committing instruction
    logic        int_pend;
    logic        exc_hit;
    logic [4:0]  sel_code;
    logic        sel_badva_we;
    logic [31:0] sel_badva;
    logic        sel_tlb;
    logic        sel_ctx;
    logic [31:0] sel_epc;
    logic [31:0] vec_base;
    logic [31:0] vec_off;
    logic        vec_ctx_we;
    logic        unused_bits;

    assign int_pend = (|(cause[15:8] & status[15:8])) & status[0] & ~status[1] & ~status[2];
    assign exc_hit  = commit_valid & (int_pend | (|exc_req));
    assign sel_epc  = commit_dslot ? (commit_pc - 32'd4) : commit_pc;
    assign vec_base = status[22] ? 32'hBFC0_0200 : ebase;

    // Only the interrupt mask/enable fields, BEV and EXL/ERL matter here
    assign unused_bits = ^{cause[31:16], cause[7:0], status[31:23], status[21:16],
                           status[7:3], tlb_refill};

    // Priority resolution: interrupt first, then fetch faults, decode faults, then data faults
    always_comb begin
        sel_code     = 5'd0;
        sel_badva_we = 1'b0;
        sel_badva    = commit_badva;
        sel_tlb      = 1'b0;
        sel_ctx      = 1'b0;
        if (int_pend) begin
            sel_code = 5'd0;
        end else if (exc_req[0]) begin          // adel_f
            sel_code     = 5'd4;
            sel_badva_we = 1'b1;
            sel_badva    = commit_pc;
        end else if (exc_req[1]) begin          // tlbl_f
            sel_code     = 5'd2;
            sel_badva_we = 1'b1;
            sel_badva    = commit_pc;
            sel_tlb      = 1'b1;
            sel_ctx      = 1'b1;
        end else if (exc_req[2]) begin          // ri
            sel_code = 5'd10;
        end else if (exc_req[3]) begin          // sys
            sel_code = 5'd8;
        end else if (exc_req[4]) begin          // bp
            sel_code = 5'd9;
        end else if (exc_req[5]) begin          // ov
            sel_code = 5'd12;
        end else if (exc_req[6]) begin          // adel_d
            sel_code     = 5'd4;
            sel_badva_we = 1'b1;
        end else if (exc_req[7]) begin          // ades_d
            sel_code     = 5'd5;
            sel_badva_we = 1'b1;
        end else if (exc_req[8]) begin          // tlbl_d
            sel_code     = 5'd2;
            sel_badva_we = 1'b1;
            sel_tlb      = 1'b1;
            sel_ctx      = 1'b1;
        end else if (exc_req[9]) begin          // tlbs_d
            sel_code     = 5'd3;
            sel_badva_we = 1'b1;
            sel_tlb      = 1'b1;
            sel_ctx      = 1'b1;
        end else if (exc_req[10]) begin         // mod
            sel_code     = 5'd1;
            sel_badva_we = 1'b1;
            sel_ctx      = 1'b1;
        end
    end

    // Vector offset and Context write strobe depend on whether refill vectoring is built in
    always_comb begin
`ifdef CP0_EXC_TLB_REFILL_EN
        vec_off    = (sel_tlb & tlb_refill & ~status[1]) ? 32'h0000_0000 : 32'h0000_0180;
        vec_ctx_we = sel_ctx;
`else
        vec_off    = 32'h0000_0180;
        vec_ctx_we = 1'b0;
`endif
    end

    // Next-state and registered-output computation for the sequencer
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        is_exception_d   = 1'b0;
        exc_code_d       = exc_code_q;
        exc_epc_d        = exc_epc_q;
        badva_we_d       = 1'b0;
        exc_badva_d      = exc_badva_q;
        ctx_we_d         = 1'b0;
        eret_d           = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (exc_hit) begin
                    state_d          = S_EXC;
                    is_exception_d   = 1'b1;
                    redirect_valid_d = 1'b1;
                    flush_d          = 1'b1;
                    exc_code_d       = sel_code;
                    exc_epc_d        = sel_epc;
                    badva_we_d       = sel_badva_we;
                    if (sel_badva_we) begin
                        exc_badva_d = sel_badva;
                    end
                    ctx_we_d         = vec_ctx_we;
                    redirect_pc_d    = vec_base + vec_off;
                end else if (commit_valid & eret_req) begin
                    state_d          = S_ERET;
                    eret_d           = 1'b1;
                    redirect_valid_d = 1'b1;
                    flush_d          = 1'b1;
                    redirect_pc_d    = eret_pc;
                end
            end
            S_EXC, S_ERET: begin
                state_d = S_FLUSH;
                cnt_d   = 4'(FLUSH_CYCLES);
                flush_d = 1'b1;
            end
            S_FLUSH: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, counter and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            cnt_q            <= 4'd0;
            is_exception_q   <= 1'b0;
            exc_code_q       <= 5'd0;
            exc_epc_q        <= 32'd0;
            badva_we_q       <= 1'b0;
            exc_badva_q      <= 32'd0;
            ctx_we_q         <= 1'b0;
            eret_q           <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            flush_q          <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            is_exception_q   <= is_exception_d;
            exc_code_q       <= exc_code_d;
            exc_epc_q        <= exc_epc_d;
            badva_we_q       <= badva_we_d;
            exc_badva_q      <= exc_badva_d;
            ctx_we_q         <= ctx_we_d;
            eret_q           <= eret_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            busy_q           <= busy_d;
        end
    end

    assign is_exception   = is_exception_q;
    assign exc_code       = exc_code_q;
    assign exc_epc        = exc_epc_q;
    assign badva_we       = badva_we_q;
    assign exc_badva      = exc_badva_q;
    assign ctx_we         = ctx_we_q;
    assign eret           = eret_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Testbench for cp0_exc_ctrl: directed scenarios plus randomized traffic against a reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
// Works with or without CP0_EXC_TLB_REFILL_EN defined.
module tb_cp0_exc_ctrl;

    localparam int F = 3;

    logic        clk;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_dslot;
    logic [31:0] commit_badva;
    logic [10:0] exc_req;
    logic        tlb_refill;
    logic        eret_req;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] ebase;
    logic [31:0] eret_pc;
    logic        is_exception;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        badva_we;
    logic [31:0] exc_badva;
    logic        ctx_we;
    logic        eret;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        busy;

    int checks = 0;
    int errors = 0;

    cp0_exc_ctrl #(.FLUSH_CYCLES(F)) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_dslot(commit_dslot),
        .commit_badva(commit_badva), .exc_req(exc_req), .tlb_refill(tlb_refill),
        .eret_req(eret_req), .status(status), .cause(cause), .ebase(ebase), .eret_pc(eret_pc),
        .is_exception(is_exception), .exc_code(exc_code), .exc_epc(exc_epc),
        .badva_we(badva_we), .exc_badva(exc_badva), .ctx_we(ctx_we), .eret(eret),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // Exception table indexed by exc_req bit; priority follows bit order after the interrupt
    // bit: 0 adel_f, 1 tlbl_f, 2 ri, 3 sys, 4 bp, 5 ov, 6 adel_d, 7 ades_d, 8 tlbl_d, 9 tlbs_d, 10 mod
    int code_of[11]   = '{4, 2, 10, 8, 9, 12, 4, 5, 2, 3, 1};
    int prio_list[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        commit_valid = 1'b0;
        exc_req      = 11'd0;
        eret_req     = 1'b0;
        tlb_refill   = 1'b0;
        commit_dslot = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (F + 2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        commit_valid = 1'b1; exc_req = 11'h7FF; eret_req = 1'b1;
        commit_pc = 32'h1234_5678; commit_badva = 32'h8765_4321;
        status = 32'h0040_FF01; cause = 32'h0000_FF00; ebase = 32'h8000_0000; eret_pc = 32'hDEAD_BEEF;
        tick(); tick();
        checks++;
        if ({is_exception, exc_code, exc_epc, badva_we, exc_badva, ctx_we, eret,
             redirect_valid, redirect_pc, flush, busy} !== 108'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0", {is_exception, exc_code, exc_epc,
                     badva_we, exc_badva, ctx_we, eret, redirect_valid, redirect_pc, flush, busy});
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release busy=%b rv=%b required 0 0", busy, redirect_valid);
        end
    endtask

    task automatic test_interrupt();
        status = 32'h0000_FF01; cause = 32'h0000_0400; ebase = 32'h8000_0000;
        commit_pc = 32'h8000_1000; commit_dslot = 1'b0; exc_req = 11'd0; commit_valid = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (is_exception !== 1'b1 || redirect_valid !== 1'b1 || flush !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL int_strobes exc=%b rv=%b fl=%b busy=%b required 1 1 1 1",
                     is_exception, redirect_valid, flush, busy);
        end
        checks++;
        if (exc_code !== 5'd0) begin
            errors++; $display("FAIL int_code got %0d required 0", exc_code);
        end
        checks++;
        if (exc_epc !== 32'h8000_1000) begin
            errors++; $display("FAIL int_epc got %h required 80001000", exc_epc);
        end
        checks++;
        if (redirect_pc !== 32'h8000_0180) begin
            errors++; $display("FAIL int_redirect got %h required 80000180", redirect_pc);
        end
        checks++;
        if (badva_we !== 1'b0 || ctx_we !== 1'b0) begin
            errors++; $display("FAIL int_badva_we got %b/%b required 0/0", badva_we, ctx_we);
        end
        for (int i = 0; i < F; i++) begin
            tick();
            checks++;
            if (flush !== 1'b1 || busy !== 1'b1 || is_exception !== 1'b0 || redirect_valid !== 1'b0) begin
                errors++;
                $display("FAIL int_flush_hold cyc %0d fl=%b busy=%b exc=%b rv=%b required 1 1 0 0",
                         i, flush, busy, is_exception, redirect_valid);
            end
        end
        tick();
        checks++;
        if (flush !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL int_release fl=%b busy=%b required 0 0", flush, busy);
        end
        drain();
    endtask

    task automatic test_priority();
        status = 32'd0; cause = 32'd0; ebase = 32'h8000_0000;
        exc_req = 11'b000_0110_0000;   // ov and adel_d
        commit_dslot = 1'b1; commit_pc = 32'h8000_2004; commit_badva = 32'h0000_1111; commit_valid = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (exc_code !== 5'd12 || exc_epc !== 32'h8000_2000 || badva_we !== 1'b0) begin
            errors++;
            $display("FAIL prio_ov code=%0d epc=%h bwe=%b required 12 80002000 0", exc_code, exc_epc, badva_we);
        end
        drain();
        // delay-slot EPC wraps below zero
        exc_req = 11'b000_0000_1000;   // sys
        commit_dslot = 1'b1; commit_pc = 32'h0000_0000; commit_valid = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (exc_code !== 5'd8 || exc_epc !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL prio_wrap code=%0d epc=%h required 8 fffffffc", exc_code, exc_epc);
        end
        drain();
        // fetch address error beats everything else and captures the PC
        exc_req = 11'h7FF; commit_pc = 32'h8000_5008; commit_badva = 32'h0000_2222; commit_valid = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (exc_code !== 5'd4 || badva_we !== 1'b1 || exc_badva !== 32'h8000_5008) begin
            errors++;
            $display("FAIL prio_adelf code=%0d bwe=%b badva=%h required 4 1 80005008", exc_code, badva_we, exc_badva);
        end
        drain();
    endtask

    task automatic test_eret();
        int fl_cnt;
        status = 32'd0; eret_pc = 32'h8000_3000; eret_req = 1'b1; commit_valid = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (eret !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_3000 || is_exception !== 1'b0) begin
            errors++;
            $display("FAIL eret_strobe eret=%b rv=%b pc=%h exc=%b required 1 1 80003000 0",
                     eret, redirect_valid, redirect_pc, is_exception);
        end
        fl_cnt = 0;
        for (int i = 0; i < 20 && flush === 1'b1; i++) begin
            fl_cnt++;
            tick();
        end
        checks++;
        if (fl_cnt != 1 + F) begin
            errors++; $display("FAIL eret_flush_len got %0d required %0d", fl_cnt, 1 + F);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL eret_busy_drop got %b required 0", busy);
        end
        drain();
        // exception wins over ERET in the same commit
        eret_req = 1'b1; exc_req = 11'b000_0001_0000; commit_valid = 1'b1;   // bp
        tick();
        idle_inputs();
        checks++;
        if (is_exception !== 1'b1 || eret !== 1'b0 || exc_code !== 5'd9) begin
            errors++;
            $display("FAIL eret_precedence exc=%b eret=%b code=%0d required 1 0 9", is_exception, eret, exc_code);
        end
        drain();
    endtask

    task automatic test_tlb_refill();
        logic [31:0] exp_pc;
        logic        exp_ctx;
        status = 32'd0; ebase = 32'h8000_0000; commit_badva = 32'h0040_0010; commit_pc = 32'h8000_4000;
        exc_req = 11'b001_0000_0000; tlb_refill = 1'b1; commit_valid = 1'b1;
        tick();
        idle_inputs();
`ifdef CP0_EXC_TLB_REFILL_EN
        exp_pc = 32'h8000_0000; exp_ctx = 1'b1;
`else
        exp_pc = 32'h8000_0180; exp_ctx = 1'b0;
`endif
        checks++;
        if (redirect_pc !== exp_pc || ctx_we !== exp_ctx) begin
            errors++;
            $display("FAIL tlb_refill_vec pc=%h ctx=%b required %h %b", redirect_pc, ctx_we, exp_pc, exp_ctx);
        end
        checks++;
        if (exc_code !== 5'd2 || badva_we !== 1'b1 || exc_badva !== 32'h0040_0010) begin
            errors++;
            $display("FAIL tlb_refill_badva code=%0d bwe=%b badva=%h required 2 1 00400010",
                     exc_code, badva_we, exc_badva);
        end
        drain();
        // BEV base
        status = 32'h0040_0000; exc_req = 11'b010_0000_0000; tlb_refill = 1'b1; commit_valid = 1'b1;
        tick();
        idle_inputs();
`ifdef CP0_EXC_TLB_REFILL_EN
        exp_pc = 32'hBFC0_0200;
`else
        exp_pc = 32'hBFC0_0380;
`endif
        checks++;
        if (redirect_pc !== exp_pc || exc_code !== 5'd3) begin
            errors++; $display("FAIL tlb_bev pc=%h code=%0d required %h 3", redirect_pc, exc_code, exp_pc);
        end
        drain();
    endtask

    task automatic test_flush_ignore_and_reset();
        int rv_seen;
        status = 32'd0; exc_req = 11'b000_0000_1000; commit_valid = 1'b1; commit_pc = 32'h8000_6000;
        tick();   // EXC shown
        tick();   // first FLUSH cycle shown; commit still offered
        checks++;
        if (is_exception !== 1'b0 || redirect_valid !== 1'b0 || flush !== 1'b1) begin
            errors++;
            $display("FAIL flush_ignore exc=%b rv=%b fl=%b required 0 0 1", is_exception, redirect_valid, flush);
        end
        idle_inputs();
        rst = 1'b0;
        tick();
        checks++;
        if ({is_exception, exc_code, exc_epc, badva_we, exc_badva, ctx_we, eret,
             redirect_valid, redirect_pc, flush, busy} !== 108'd0) begin
            errors++;
            $display("FAIL flush_reset got %h required 0", {is_exception, exc_code, exc_epc,
                     badva_we, exc_badva, ctx_we, eret, redirect_valid, redirect_pc, flush, busy});
        end
        rst = 1'b1;
        rv_seen = 0;
        for (int i = 0; i < F + 3; i++) begin
            tick();
            if (redirect_valid === 1'b1 || busy === 1'b1) rv_seen++;
        end
        checks++;
        if (rv_seen != 0) begin
            errors++; $display("FAIL flush_reset_quiet got %0d active cycles required 0", rv_seen);
        end
    endtask

    task automatic test_random();
        int          m_left;
        logic [4:0]  m_code;
        logic [31:0] m_epc, m_badva, m_rpc, off;
        logic [6:0]  e_str;   // {is_exception, badva_we, ctx_we, eret, redirect_valid, flush, busy}
        logic        intp, e_exc, e_bwe, e_ctx, e_eret, e_rv, e_fl;
        int          win;
        rst = 1'b0; idle_inputs(); tick(); rst = 1'b1;
        m_left = 0; m_code = 0; m_epc = 0; m_badva = 0; m_rpc = 0;
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 59) != 0);
            commit_valid = $urandom_range(0, 1);
            commit_pc    = $urandom;
            commit_dslot = $urandom_range(0, 1);
            commit_badva = $urandom;
            case ($urandom_range(0, 3))
                0: exc_req = 11'd0;
                1: exc_req = 11'd1 << $urandom_range(0, 10);
                2: exc_req = 11'($urandom);
                default: exc_req = 11'd0;
            endcase
            tlb_refill = $urandom_range(0, 1);
            eret_req   = $urandom_range(0, 1);
            status     = $urandom;
            if ($urandom_range(0, 1) == 1) status[2:0] = 3'b001;
            cause      = $urandom;
            ebase      = $urandom & 32'hFFFF_F000;
            eret_pc    = $urandom;

            intp = ((cause[15:8] & status[15:8]) != 8'd0) && status[0] && !status[1] && !status[2];
            e_exc = 0; e_bwe = 0; e_ctx = 0; e_eret = 0; e_rv = 0; e_fl = 0;
            if (!rst) begin
                m_left = 0; m_code = 0; m_epc = 0; m_badva = 0; m_rpc = 0;
            end else if (m_left == 0 && commit_valid && (intp || exc_req != 0)) begin
                win = -1;
                if (!intp) begin
                    for (int k = 10; k >= 0; k--) if (exc_req[prio_list[k]]) win = prio_list[k];
                end
                m_code = (win < 0) ? 5'd0 : 5'(code_of[win]);
                m_epc  = commit_dslot ? commit_pc - 32'd4 : commit_pc;
                if (win == 0 || win == 1) begin
                    e_bwe = 1; m_badva = commit_pc;
                end else if (win >= 6) begin
                    e_bwe = 1; m_badva = commit_badva;
                end
                off = 32'h180;
`ifdef CP0_EXC_TLB_REFILL_EN
                if ((win == 1 || win == 8 || win == 9) && tlb_refill && !status[1]) off = 32'h0;
                e_ctx = (win == 1 || win == 8 || win == 9 || win == 10);
`endif
                m_rpc = (status[22] ? 32'hBFC0_0200 : ebase) + off;
                e_exc = 1; e_rv = 1; e_fl = 1;
                m_left = 1 + F;
            end else if (m_left == 0 && commit_valid && eret_req) begin
                m_rpc = eret_pc;
                e_eret = 1; e_rv = 1; e_fl = 1;
                m_left = 1 + F;
            end else if (m_left > 0) begin
                m_left--;
                e_fl = (m_left > 0);
            end
            e_str = {e_exc, e_bwe, e_ctx, e_eret, e_rv, e_fl, m_left > 0};
            tick();
            checks++;
            if ({is_exception, badva_we, ctx_we, eret, redirect_valid, flush, busy} !== e_str) begin
                errors++;
                $display("FAIL rnd_strobes cyc %0d got %b required %b", c,
                         {is_exception, badva_we, ctx_we, eret, redirect_valid, flush, busy}, e_str);
            end
            checks++;
            if (exc_code !== m_code) begin
                errors++; $display("FAIL rnd_code cyc %0d got %0d required %0d", c, exc_code, m_code);
            end
            checks++;
            if (exc_epc !== m_epc) begin
                errors++; $display("FAIL rnd_epc cyc %0d got %h required %h", c, exc_epc, m_epc);
            end
            checks++;
            if (exc_badva !== m_badva) begin
                errors++; $display("FAIL rnd_badva cyc %0d got %h required %h", c, exc_badva, m_badva);
            end
            checks++;
            if (redirect_pc !== m_rpc) begin
                errors++; $display("FAIL rnd_redirect cyc %0d got %h required %h", c, redirect_pc, m_rpc);
            end
        end
        rst = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        commit_pc = 0; commit_badva = 0; status = 0; cause = 0; ebase = 0; eret_pc = 0;
        @(negedge clk);
        test_reset();
        test_interrupt();
        test_priority();
        test_eret();
        test_tlb_refill();
        test_flush_ignore_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
